// File: rtl/uart_dbg_bridge_if.sv
// Debug command bus between the UART bridge (master) and the debug module (slave).
interface uart_dbg_bridge_if;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;

    modport master (
        output dbg_cmd_o, dbg_addr_o, dbg_data_o,
        input  dbg_data_i, dbg_ready_i
    );

    modport slave (
        input  dbg_cmd_o, dbg_addr_o, dbg_data_o,
        output dbg_data_i, dbg_ready_i
    );
endinterface

// File: rtl/uart_dbg_bridge.sv
// UART-to-debug-bus bridge: decodes 9-byte command frames from RX, issues them on the
// debug bus, and returns the 32-bit read data over TX as four 8N1 bytes.
module uart_dbg_bridge #(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              uart_rx_i,
    output logic              uart_tx_o,
    uart_dbg_bridge_if.master dbg,
    output logic              busy_o,
    output logic              frame_err_o
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RESP} fr_state_t;

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick, rx_valid, rx_err;

    fr_state_t       fr_state, fr_next;
    logic [1:0]      byte_cnt;
    logic [7:0]      cmd_q;
    logic [31:0]     addr_q, data_q, resp_q;
    logic            blank_q;
    logic [TW-1:0]   idle_cnt;
    logic            timeout;
    logic [8:0]      tx_sh;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic [1:0]      tx_idx;
    logic            bit_end, tx_last;

    // The start bit is checked at half a bit time, every later sample a full bit apart.
    always_comb begin
        rx_tick  = (rx_state == R_START) ? (rx_cnt == CW'(HALF - 1)) : (rx_cnt == CW'(CPB - 1));
        rx_next  = rx_state;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_s2) rx_next = R_START;
            R_START: if (rx_tick) rx_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP: begin
                if (rx_tick) begin
                    rx_next  = R_IDLE;
                    rx_valid = rx_s2;
                    rx_err   = !rx_s2;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rx_i;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == R_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == R_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // A completed byte takes priority over an expiring inter-byte timeout.
    always_comb begin
        bit_end = (tx_cnt == CW'(CPB - 1));
        tx_last = bit_end && (tx_bit == 4'd9) && (tx_idx == 2'd3);
        timeout = 1'b0;
        fr_next = fr_state;
        case (fr_state)
            S_CMD: if (rx_valid && rx_shift != 8'h00) fr_next = S_ADDR;
            S_ADDR, S_DATA: begin
                if (rx_err) begin
                    fr_next = S_CMD;
                end else if (rx_valid) begin
                    if (byte_cnt == 2'd3) fr_next = (fr_state == S_ADDR) ? S_DATA : S_ISSUE;
                end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    fr_next = S_CMD;
                end
            end
            S_ISSUE: fr_next = S_WAIT;
            S_WAIT:  if (!blank_q && dbg.dbg_ready_i) fr_next = S_RESP;
            S_RESP:  if (tx_last) fr_next = S_CMD;
            default: fr_next = S_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            fr_state       <= S_CMD;
            frame_err_o    <= 1'b0;
            blank_q        <= 1'b0;
            idle_cnt       <= '0;
            byte_cnt       <= '0;
            cmd_q          <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            resp_q         <= '0;
            dbg.dbg_cmd_o  <= '0;
            dbg.dbg_addr_o <= '0;
            dbg.dbg_data_o <= '0;
            busy_o         <= 1'b0;
            uart_tx_o      <= 1'b1;
            tx_sh          <= '1;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_idx         <= '0;
        end else begin
            fr_state    <= fr_next;
            frame_err_o <= rx_err || timeout;
            blank_q     <= (fr_state == S_ISSUE);
            idle_cnt    <= ((fr_state == S_ADDR || fr_state == S_DATA) && !rx_valid) ?
                           idle_cnt + 1'b1 : '0;
            if (fr_state == S_CMD) byte_cnt <= '0;
            else if (rx_valid)     byte_cnt <= byte_cnt + 1'b1;
            if (rx_valid) begin
                case (fr_state)
                    S_CMD:   cmd_q  <= rx_shift;
                    S_ADDR:  addr_q <= {addr_q[23:0], rx_shift};
                    S_DATA:  data_q <= {data_q[23:0], rx_shift};
                    default: ;
                endcase
            end
            // The last data byte bypasses data_q so the bus is valid during S_ISSUE.
            if (fr_state == S_DATA && fr_next == S_ISSUE) begin
                dbg.dbg_cmd_o  <= cmd_q;
                dbg.dbg_addr_o <= addr_q;
                dbg.dbg_data_o <= {data_q[23:0], rx_shift};
                busy_o         <= 1'b1;
            end
            if (fr_state == S_WAIT && fr_next == S_RESP) begin
                dbg.dbg_cmd_o <= '0;
                resp_q        <= {dbg.dbg_data_i[23:0], 8'h00};
                tx_sh         <= {1'b1, dbg.dbg_data_i[31:24]};
                uart_tx_o     <= 1'b0;
                tx_cnt        <= '0;
                tx_bit        <= '0;
                tx_idx        <= '0;
            end
            if (fr_state == S_RESP) begin
                tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
                if (bit_end) begin
                    if (tx_bit == 4'd9) begin
                        tx_bit <= '0;
                        tx_idx <= tx_idx + 1'b1;
                        if (tx_last) begin
                            uart_tx_o <= 1'b1;
                            busy_o    <= 1'b0;
                        end else begin
                            uart_tx_o <= 1'b0;
                            tx_sh     <= {1'b1, resp_q[31:24]};
                            resp_q    <= {resp_q[23:0], 8'h00};
                        end
                    end else begin
                        tx_bit    <= tx_bit + 1'b1;
                        uart_tx_o <= tx_sh[0];
                        tx_sh     <= {1'b1, tx_sh[8:1]};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge: frames over RX, a small debug-module model, TX decoding.
module tb_uart_dbg_bridge;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rstn_i;
    logic uart_rx_i;
    logic uart_tx_o;
    logic busy_o;
    logic frame_err_o;

    uart_dbg_bridge_if dbg_if ();

    uart_dbg_bridge #(
        .CLK_FREQ       (1000000),
        .BAUD           (100000),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .uart_rx_i   (uart_rx_i),
        .uart_tx_o   (uart_tx_o),
        .dbg         (dbg_if),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Error pulses and busy falling edges, observed on the falling clock edge.
    int   err_cnt = 0, err_cyc = 0, busy_falls = 0, busy_fall_cyc = 0;
    logic busy_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (frame_err_o === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (busy_prev && busy_o === 1'b0) begin
            busy_falls++;
            busy_fall_cyc = cyc;
        end
        busy_prev = (busy_o === 1'b1);
    end

    // Debug module model: ready 3 cycles after a command appears, or held high when asked.
    int          hi = 0, last_hi = 0, cmds_issued = 0;
    logic [7:0]  last_cmd = '0;
    logic [31:0] last_addr = '0, last_data = '0;
    logic        busy_at_issue = 1'b0;
    bit          hold_ready = 1'b0, stall = 1'b0;
    initial begin
        dbg_if.dbg_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dbg_if.dbg_cmd_o != 8'h00) begin
                if (hi == 0) begin
                    last_cmd      = dbg_if.dbg_cmd_o;
                    last_addr     = dbg_if.dbg_addr_o;
                    last_data     = dbg_if.dbg_data_o;
                    busy_at_issue = busy_o;
                end
                hi++;
                if (hold_ready || (hi == 4 && !stall)) dbg_if.dbg_ready_i = 1'b1;
            end else begin
                if (hi != 0) begin
                    last_hi = hi;
                    cmds_issued++;
                end
                hi = 0;
                dbg_if.dbg_ready_i = hold_ready;
            end
        end
    end

    // TX decoder: byte value, stop bit and start cycle of every byte sent.
    logic [7:0] txq[$];
    bit         stopq[$];
    int         startq[$];
    initial forever begin : tx_mon
        int         st;
        logic [7:0] b;
        @(negedge clk);
        if (uart_tx_o === 1'b0 && rstn_i === 1'b1) begin
            st = cyc;
            repeat (CPB / 2) @(negedge clk);
            if (uart_tx_o === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx_o;
                end
                repeat (CPB) @(negedge clk);
                stopq.push_back(uart_tx_o === 1'b1);
                txq.push_back(b);
                startq.push_back(st);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_i = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        logic [71:0] fr;
        fr = {c, a, d};
        for (int i = 8; i >= 0; i--) send_byte(fr[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_resp(input string tag, input int target);
        int k;
        k = 0;
        while (busy_falls < target && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 32'(busy_falls >= target), 32'd1);
    endtask

    task automatic clear_tx();
        txq.delete();
        stopq.delete();
        startq.delete();
    endtask

    task automatic check_tx(input string tag, input logic [31:0] exp);
        check({tag, " count"}, txq.size(), 32'd4);
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            check({tag, " byte"}, 32'(txq[i]), 32'(exp[31 - 8*i -: 8]));
            check({tag, " stop"}, 32'(stopq[i]), 32'd1);
        end
        check({tag, " line idle"}, 32'(uart_tx_o), 32'd1);
    endtask

    initial begin
        int tgt, e0, n0, t0, k;
        rstn_i = 1'b0;
        uart_rx_i = 1'b1;
        dbg_if.dbg_data_i = 32'h0;
        idle(3);
        check("reset tx", 32'(uart_tx_o), 32'd1);
        check("reset cmd", 32'(dbg_if.dbg_cmd_o), 32'd0);
        check("reset addr", dbg_if.dbg_addr_o, 32'd0);
        check("reset data", dbg_if.dbg_data_o, 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset err", 32'(frame_err_o), 32'd0);
        rstn_i = 1'b1;
        idle(20);

        // Write frame
        clear_tx();
        tgt = busy_falls + 1;
        send_frame(8'h02, 32'h0000_4000, 32'hDEAD_BEEF);
        wait_resp("t1 done", tgt);
        check("t1 cmd", 32'(last_cmd), 32'h02);
        check("t1 addr", last_addr, 32'h0000_4000);
        check("t1 data", last_data, 32'hDEAD_BEEF);
        check("t1 cmd cycles", last_hi, 32'd4);
        check("t1 busy at issue", 32'(busy_at_issue), 32'd1);
        check_tx("t1 tx", 32'h0);
        check("t1 byte spacing", (startq.size() >= 2) ? startq[1] - startq[0] : 0, 32'd100);
        check("t1 busy span", (startq.size() >= 1) ? busy_fall_cyc - startq[0] : 0, 32'd400);
        check("t1 addr held", dbg_if.dbg_addr_o, 32'h0000_4000);
        check("t1 cmd cleared", 32'(dbg_if.dbg_cmd_o), 32'd0);
        check("t1 no err", err_cnt, 32'd0);

        // Read frame
        clear_tx();
        dbg_if.dbg_data_i = 32'h1234_5678;
        tgt = busy_falls + 1;
        send_frame(8'h01, 32'h0000_8000, 32'h0);
        wait_resp("t2 done", tgt);
        check("t2 addr", last_addr, 32'h0000_8000);
        check_tx("t2 tx", 32'h1234_5678);

        // Bad stop bit on the third byte
        e0 = err_cnt;
        n0 = cmds_issued;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b0);
        uart_rx_i = 1'b1;
        idle(30);
        check("t3 err pulse", err_cnt - e0, 32'd1);
        check("t3 no issue", cmds_issued - n0, 32'd0);
        check("t3 cmd idle", 32'(dbg_if.dbg_cmd_o), 32'd0);
        clear_tx();
        dbg_if.dbg_data_i = 32'hCAFE_F00D;
        tgt = busy_falls + 1;
        send_frame(8'h03, 32'h0000_0100, 32'h55AA_55AA);
        wait_resp("t3 done", tgt);
        check("t3 cmd", 32'(last_cmd), 32'h03);
        check("t3 data", last_data, 32'h55AA_55AA);
        check_tx("t3 tx", 32'hCAFE_F00D);

        // Inter-byte timeout
        e0 = err_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        t0 = cyc;
        k = 0;
        while (err_cnt == e0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        idle(5);
        check("t4 timeout pulse", err_cnt - e0, 32'd1);
        check("t4 timeout delay window", 32'((err_cyc - t0) >= 190 && (err_cyc - t0) <= 210), 32'd1);
        clear_tx();
        tgt = busy_falls + 1;
        send_frame(8'h04, 32'h0000_0200, 32'h0000_0001);
        wait_resp("t4 done", tgt);
        check("t4 cmd", 32'(last_cmd), 32'h04);
        check("t4 addr", last_addr, 32'h0000_0200);

        // Glitch, leading zero bytes, leftover ready level
        e0 = err_cnt;
        n0 = cmds_issued;
        uart_rx_i = 1'b0;
        idle(3);
        uart_rx_i = 1'b1;
        idle(40);
        check("t5 glitch no err", err_cnt - e0, 32'd0);
        check("t5 glitch no issue", cmds_issued - n0, 32'd0);
        clear_tx();
        hold_ready = 1'b1;
        dbg_if.dbg_data_i = 32'h8421_0F3C;
        tgt = busy_falls + 1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_frame(8'h05, 32'hA5A5_0004, 32'h1122_3344);
        wait_resp("t5 done", tgt);
        hold_ready = 1'b0;
        check("t5 cmd", 32'(last_cmd), 32'h05);
        check("t5 addr", last_addr, 32'hA5A5_0004);
        check("t5 data", last_data, 32'h1122_3344);
        check("t5 blank cycles", last_hi, 32'd3);
        check_tx("t5 tx", 32'h8421_0F3C);

        // Reset while waiting for ready
        stall = 1'b1;
        send_frame(8'h07, 32'h0000_0300, 32'h0);
        idle(20);
        check("t6 waiting cmd", 32'(dbg_if.dbg_cmd_o), 32'h07);
        check("t6 waiting busy", 32'(busy_o), 32'd1);
        #3 rstn_i = 1'b0;
        #1;
        check("t6 rst cmd", 32'(dbg_if.dbg_cmd_o), 32'd0);
        check("t6 rst tx", 32'(uart_tx_o), 32'd1);
        check("t6 rst busy", 32'(busy_o), 32'd0);
        idle(3);
        rstn_i = 1'b1;
        stall = 1'b0;
        idle(10);

        // Reset in the middle of a TX byte
        dbg_if.dbg_data_i = 32'h0F0F_0F0F;
        send_frame(8'h08, 32'h0000_0400, 32'h0);
        k = 0;
        while (uart_tx_o !== 1'b0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t6 tx started", 32'(uart_tx_o), 32'd0);
        idle(35);
        #3 rstn_i = 1'b0;
        #1;
        check("t6 mid-tx rst tx", 32'(uart_tx_o), 32'd1);
        check("t6 mid-tx rst busy", 32'(busy_o), 32'd0);
        check("t6 mid-tx rst cmd", 32'(dbg_if.dbg_cmd_o), 32'd0);
        idle(3);
        rstn_i = 1'b1;
        idle(150);
        clear_tx();
        dbg_if.dbg_data_i = 32'h9ABC_DEF0;
        tgt = busy_falls + 1;
        send_frame(8'h09, 32'h0000_0500, 32'h7777_0000);
        wait_resp("t6 done", tgt);
        check("t6 cmd", 32'(last_cmd), 32'h09);
        check("t6 addr", last_addr, 32'h0000_0500);
        check_tx("t6 tx", 32'h9ABC_DEF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
